// File: rtl/regfile_nrnw.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// regfile_nrnw
//
// Parametrised multi-port integer register file with NREAD combinational read
// ports, NWRITE write ports, an optional hard-wired zero register, optional
// write-to-read bypass and a per-register busy scoreboard.
//
// The storage array has no reset flops. After reset a clear engine walks every
// address and writes zero, one address per cycle. o_ready tells the pipeline
// when the file can be used.
//
// FSM state encoding: CLEAR = 1'b0, RUN = 1'b1.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   o_ready     1 once the clear engine has zeroed every register
//   i_raddr     packed read addresses, port k at [k*ALEN +: ALEN]
//   o_rdata     packed read data,      port k at [k*DLEN +: DLEN]
//   o_rbusy     busy status of the register addressed by each read port
//   i_wen       per write port enable
//   i_waddr     packed write addresses, port j at [j*ALEN +: ALEN]
//   i_wdata     packed write data,      port j at [j*DLEN +: DLEN]
//   i_set_busy  mark i_set_addr as having a pending producer
//   i_set_addr  register to mark busy
//
// Handshake: there is no valid/ready pairing on the data ports. Each write
// port and i_set_busy is a single-cycle qualifier sampled at the rising edge.
// All of them are ignored while o_ready is low. Reads are combinational and
// return zero with busy=0 while o_ready is low.
// -----------------------------------------------------------------------------
module regfile_nrnw #(
    parameter int DLEN     = 32,
    parameter int ALEN     = 5,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   o_ready,
    input  logic [NREAD*ALEN-1:0]  i_raddr,
    output logic [NREAD*DLEN-1:0]  o_rdata,
    output logic [NREAD-1:0]       o_rbusy,
    input  logic [NWRITE-1:0]      i_wen,
    input  logic [NWRITE*ALEN-1:0] i_waddr,
    input  logic [NWRITE*DLEN-1:0] i_wdata,
    input  logic                   i_set_busy,
    input  logic [ALEN-1:0]        i_set_addr
);

    localparam int RF_WORDS = 1 << ALEN;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e              state_q;
    logic [ALEN-1:0]     clr_cnt_q;
    logic                ready_q;
    logic [DLEN-1:0]     rf_q [RF_WORDS];
    logic [RF_WORDS-1:0] busy_q;
    logic [RF_WORDS-1:0] busy_d;
    logic [NWRITE-1:0]   wvalid;
    logic                set_valid;

    // A write takes effect only in RUN and only when it does not target the
    // hard-wired zero register. Bypass and busy clearing both use this.
    always_comb begin
        wvalid = '0;
        for (int j = 0; j < NWRITE; j++) begin
            wvalid[j] = i_wen[j] && (state_q == ST_RUN) &&
                        !((ZERO_REG != 0) && (i_waddr[j*ALEN +: ALEN] == '0));
        end
    end

    assign set_valid = i_set_busy && (state_q == ST_RUN) &&
                       !((ZERO_REG != 0) && (i_set_addr == '0));

    // Clear/run sequencer. The counter wraps to zero on the final clear
    // cycle, so no separate terminal handling is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == {ALEN{1'b1}}) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_cnt_q <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = ready_q;

    // Storage without reset. Ports are visited in ascending order so the
    // highest-index port wins when two ports write the same address.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            rf_q[clr_cnt_q] <= '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wvalid[j]) begin
                    rf_q[i_waddr[j*ALEN +: ALEN]] <= i_wdata[j*DLEN +: DLEN];
                end
            end
        end
    end

    // Scoreboard. Writes clear first, then a set on the same address
    // overrides because it announces a new producer.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWRITE; j++) begin
            if (wvalid[j]) begin
                busy_d[i_waddr[j*ALEN +: ALEN]] = 1'b0;
            end
        end
        if (set_valid) begin
            busy_d[i_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports. Later matching write ports override earlier ones, giving
    // the same highest-index priority as the storage update.
    always_comb begin
        logic [ALEN-1:0] ra;
        ra      = '0;
        o_rdata = '0;
        o_rbusy = '0;
        if (state_q == ST_RUN) begin
            for (int k = 0; k < NREAD; k++) begin
                ra                     = i_raddr[k*ALEN +: ALEN];
                o_rdata[k*DLEN +: DLEN] = rf_q[ra];
                o_rbusy[k]             = busy_q[ra];
                if ((ZERO_REG != 0) && (ra == '0)) begin
                    o_rdata[k*DLEN +: DLEN] = '0;
                end
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWRITE; j++) begin
                        if (wvalid[j] && (i_waddr[j*ALEN +: ALEN] == ra)) begin
                            o_rdata[k*DLEN +: DLEN] = i_wdata[j*DLEN +: DLEN];
                            o_rbusy[k]             = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_nrnw.sv
`timescale 1ns/1ps
module tb_regfile_nrnw;

    localparam int DL    = 32;
    localparam int AL    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int WORDS = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                ready;
    logic [NR*AL-1:0]    raddr;
    logic [NR*DL-1:0]    rdata;
    logic [NR-1:0]       rbusy;
    logic [NW-1:0]       wen;
    logic [NW*AL-1:0]    waddr;
    logic [NW*DL-1:0]    wdata;
    logic                set_busy;
    logic [AL-1:0]       set_addr;

    int checks   = 0;
    int failures = 0;

    regfile_nrnw #(
        .DLEN(DL), .ALEN(AL), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_ready    (ready),
        .i_raddr    (raddr),
        .o_rdata    (rdata),
        .o_rbusy    (rbusy),
        .i_wen      (wen),
        .i_waddr    (waddr),
        .i_wdata    (wdata),
        .i_set_busy (set_busy),
        .i_set_addr (set_addr)
    );

    // ---------------- reference model ----------------
    // Architectural view: a zeroed array once ready, a busy flag per register,
    // and a count of edges since reset release.
    logic [DL-1:0] m_rf [WORDS];
    bit            m_busy [WORDS];
    int            m_edges;
    bit            m_ready;

    task automatic model_reset();
        for (int i = 0; i < WORDS; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
        m_edges = 0;
        m_ready = 1'b0;
    endtask

    function automatic logic [DL-1:0] exp_rdata(int k);
        logic [AL-1:0] a;
        logic [DL-1:0] d;
        a = raddr[k*AL +: AL];
        if (!m_ready || a == 0) return '0;
        d = m_rf[a];
        for (int j = 0; j < NW; j++)
            if (wen[j] && waddr[j*AL +: AL] == a) d = wdata[j*DL +: DL];
        return d;
    endfunction

    function automatic logic exp_rbusy(int k);
        logic [AL-1:0] a;
        logic b;
        a = raddr[k*AL +: AL];
        if (!m_ready || a == 0) return 1'b0;
        b = m_busy[a];
        for (int j = 0; j < NW; j++)
            if (wen[j] && waddr[j*AL +: AL] == a) b = 1'b0;
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        raddr    = '0;
        wen      = '0;
        waddr    = '0;
        wdata    = '0;
        set_busy = 1'b0;
        set_addr = '0;
    endtask

    task automatic set_r(int k, logic [AL-1:0] a);
        raddr[k*AL +: AL] = a;
    endtask

    task automatic set_w(int j, logic [AL-1:0] a, logic [DL-1:0] d);
        wen[j]            = 1'b1;
        waddr[j*AL +: AL] = a;
        wdata[j*DL +: DL] = d;
    endtask

    task automatic drive_random(int amax);
        for (int k = 0; k < NR; k++) set_r(k, AL'($urandom_range(0, amax)));
        for (int j = 0; j < NW; j++) begin
            wen[j]            = 1'($urandom_range(0, 1));
            waddr[j*AL +: AL] = AL'($urandom_range(0, amax));
            wdata[j*DL +: DL] = $urandom;
        end
        set_busy = ($urandom_range(0, 2) == 0);
        set_addr = AL'($urandom_range(0, amax));
    endtask

    // Advance one rising edge and apply its effect to the model.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (!m_ready) begin
            m_edges++;
            if (m_edges == WORDS) m_ready = 1'b1;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wen[j] && waddr[j*AL +: AL] != 0) begin
                    m_rf[waddr[j*AL +: AL]]   = wdata[j*DL +: DL];
                    m_busy[waddr[j*AL +: AL]] = 1'b0;
                end
            end
            if (set_busy && set_addr != 0) m_busy[set_addr] = 1'b1;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        for (int c = 0; c < 3; c++) begin
            drive_random(31);
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || rdata !== '0 || rbusy !== '0) begin
                failures++;
                $display("FAIL reset_hold: ready=%b rdata=%h rbusy=%b want 0/0/0", ready, rdata, rbusy);
            end
            tick();
        end
        rst_n = 1'b1;
        for (int c = 0; c < WORDS; c++) begin
            drive_random(31);
            @(negedge clk);
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL clear_ready: edge=%0d ready=%b want 0", c, ready);
            end
            for (int k = 0; k < NR; k++) begin
                checks++;
                if (rdata[k*DL +: DL] !== 32'h0 || rbusy[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL clear_read: port=%0d rdata=%h rbusy=%b want 0/0", k, rdata[k*DL +: DL], rbusy[k]);
                end
            end
            tick();
        end
        drive_idle();
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_clear: ready=%b want 1", ready);
        end
        for (int a = 0; a < WORDS; a++) begin
            set_r(0, AL'(a));
            set_r(1, AL'(WORDS - 1 - a));
            @(negedge clk);
            checks++;
            if (rdata !== '0 || rbusy !== '0) begin
                failures++;
                $display("FAIL cleared_contents: addr=%0d rdata=%h rbusy=%b want 0", a, rdata, rbusy);
            end
            tick();
        end
    endtask

    task automatic test_bypass_write();
        drive_idle();
        set_w(0, 5'd5, 32'hDEADBEEF);
        set_r(0, 5'd5);
        set_r(1, 5'd6);
        @(negedge clk);
        checks++;
        if (rdata[0 +: DL] !== 32'hDEADBEEF || rbusy[0] !== 1'b0) begin
            failures++;
            $display("FAIL bypass_same_cycle: rdata=%h rbusy=%b want deadbeef/0", rdata[0 +: DL], rbusy[0]);
        end
        tick();
        drive_idle();
        set_r(0, 5'd5);
        @(negedge clk);
        checks++;
        if (rdata[0 +: DL] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_stored: rdata=%h want deadbeef", rdata[0 +: DL]);
        end
        tick();
    endtask

    task automatic test_dual_write();
        drive_idle();
        set_w(0, 5'd7, 32'h11111111);
        set_w(1, 5'd7, 32'h22222222);
        set_r(0, 5'd7);
        set_r(1, 5'd7);
        @(negedge clk);
        checks++;
        if (rdata !== {32'h22222222, 32'h22222222}) begin
            failures++;
            $display("FAIL dual_bypass: rdata=%h want 2222222222222222", rdata);
        end
        tick();
        drive_idle();
        set_r(1, 5'd7);
        @(negedge clk);
        checks++;
        if (rdata[DL +: DL] !== 32'h22222222) begin
            failures++;
            $display("FAIL dual_stored: rdata=%h want 22222222", rdata[DL +: DL]);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        drive_idle();
        set_w(0, 5'd0, 32'hFFFFFFFF);
        set_busy = 1'b1;
        set_addr = 5'd0;
        @(negedge clk);
        checks++;
        if (rdata[0 +: DL] !== 32'h0 || rbusy[0] !== 1'b0) begin
            failures++;
            $display("FAIL zero_same_cycle: rdata=%h rbusy=%b want 0/0", rdata[0 +: DL], rbusy[0]);
        end
        tick();
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rdata !== '0 || rbusy !== '0) begin
                failures++;
                $display("FAIL zero_after: cycle=%0d rdata=%h rbusy=%b want 0/0", c, rdata, rbusy);
            end
            tick();
        end
    endtask

    task automatic test_scoreboard();
        drive_idle();
        set_busy = 1'b1;
        set_addr = 5'd9;
        set_r(0, 5'd9);
        @(negedge clk);
        checks++;
        if (rbusy[0] !== 1'b0) begin
            failures++;
            $display("FAIL busy_before_set: rbusy=%b want 0", rbusy[0]);
        end
        tick();
        drive_idle();
        set_r(0, 5'd9);
        @(negedge clk);
        checks++;
        if (rbusy[0] !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_set: rbusy=%b want 1", rbusy[0]);
        end
        set_w(0, 5'd9, 32'hA5A5A5A5);
        #1;
        checks++;
        if (rbusy[0] !== 1'b0 || rdata[0 +: DL] !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL busy_write_cycle: rbusy=%b rdata=%h want 0/a5a5a5a5", rbusy[0], rdata[0 +: DL]);
        end
        tick();
        drive_idle();
        set_r(0, 5'd9);
        @(negedge clk);
        checks++;
        if (rbusy[0] !== 1'b0 || rdata[0 +: DL] !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL busy_after_write: rbusy=%b rdata=%h want 0/a5a5a5a5", rbusy[0], rdata[0 +: DL]);
        end
        tick();
        set_w(1, 5'd9, 32'h5A5A5A5A);
        set_busy = 1'b1;
        set_addr = 5'd9;
        tick();
        drive_idle();
        set_r(1, 5'd9);
        @(negedge clk);
        checks++;
        if (rbusy[1] !== 1'b1 || rdata[DL +: DL] !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL set_wins: rbusy=%b rdata=%h want 1/5a5a5a5a", rbusy[1], rdata[DL +: DL]);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive_random(7);
            @(negedge clk);
            checks++;
            if (ready !== m_ready) begin
                failures++;
                $display("FAIL rand_ready: cycle=%0d ready=%b want %b", c, ready, m_ready);
            end
            for (int k = 0; k < NR; k++) begin
                checks++;
                if (rdata[k*DL +: DL] !== exp_rdata(k) || rbusy[k] !== exp_rbusy(k)) begin
                    failures++;
                    $display("FAIL rand_read: cycle=%0d port=%0d rdata=%h rbusy=%b want %h/%b",
                             c, k, rdata[k*DL +: DL], rbusy[k], exp_rdata(k), exp_rbusy(k));
                end
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_reset_midrun();
        drive_idle();
        set_w(1, 5'd3, 32'h12345678);
        set_busy = 1'b1;
        set_addr = 5'd3;
        tick();
        drive_idle();
        set_r(0, 5'd3);
        @(negedge clk);
        checks++;
        if (rdata[0 +: DL] !== 32'h12345678 || rbusy[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre: rdata=%h rbusy=%b want 12345678/1", rdata[0 +: DL], rbusy[0]);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ready !== 1'b0 || rbusy !== '0 || rdata !== '0) begin
            failures++;
            $display("FAIL midrun_async: ready=%b rbusy=%b rdata=%h want 0/0/0", ready, rbusy, rdata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < WORDS; c++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL midrun_clear: edge=%0d ready=%b want 0", c, ready);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || rdata[0 +: DL] !== 32'h0 || rbusy[0] !== 1'b0) begin
            failures++;
            $display("FAIL midrun_after: ready=%b rdata=%h rbusy=%b want 1/0/0", ready, rdata[0 +: DL], rbusy[0]);
        end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_bypass_write();
        test_dual_write();
        test_zero_reg();
        test_scoreboard();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/regfile_nrnw.md
# regfile_nrnw

Parametrised multi-port integer register file for the RISC-V core. It has NREAD combinational read ports and NWRITE write ports, optional hard-wired zero register and write-to-read bypass. A per-register busy scoreboard lets issue logic detect pending producers. After reset, the array is zeroed by a sequential clear engine, so storage needs no reset flops; o_ready gates use by the pipeline.

## Interface
- DLEN, 32, data width per register
- ALEN, 5, address width; RF_WORDS = 1 << ALEN
- NREAD, 2, number of read ports (1..4)
- NWRITE, 1, number of write ports (1..2)
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1: same-cycle write data forwarded to matching read ports
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- o_ready  out  1  high when clear is complete and the file is usable
- i_raddr  in  NREAD*ALEN  packed read addresses, port k at [k*ALEN +: ALEN]
- o_rdata  out  NREAD*DLEN  packed read data, port k at [k*DLEN +: DLEN]
- o_rbusy  out  NREAD  busy status of each read port's register
- i_wen  in  NWRITE  per-port write enable
- i_waddr  in  NWRITE*ALEN  packed write addresses
- i_wdata  in  NWRITE*DLEN  packed write data
- i_set_busy  in  1  mark i_set_addr as having a pending producer
- i_set_addr  in  ALEN  register to mark busy

## Operation
- FSM states: CLEAR and RUN.
- Reset (rst_n=0), asynchronous:
  - state=CLEAR, clear counter=0, all busy bits=0.
  - o_ready=0, o_rdata=0, o_rbusy=0.
- CLEAR state:
  - Each cycle writes 0 to rf[counter] and increments the counter.
  - When counter==RF_WORDS-1, the next state is RUN.
  - i_wen and i_set_busy are ignored.
  - o_rdata=0 and o_rbusy=0 on all ports.
- RUN state:
  - o_ready=1. The FSM stays in RUN until the next reset.
- Write:
  - Port j writes rf[waddr_j] <= wdata_j at the edge when wen_j=1.
  - If ZERO_REG=1 and waddr_j==0, the write is dropped.
  - Two ports writing the same address: the higher port index wins.
- Read: o_rdata[k] = rf[raddr_k], combinational.
  - If ZERO_REG=1 and raddr_k==0, o_rdata[k]=0.
  - If BYPASS=1 and a write port is writing raddr_k this cycle (enabled, non-dropped), o_rdata[k] = that write data. The highest matching index is used.
- Scoreboard, one busy bit per register:
  - i_set_busy sets busy[i_set_addr] at the edge.
  - Any enabled, non-dropped write clears busy[waddr] at the edge.
  - Set and write to the same address in the same cycle: set wins, busy=1 (new producer).
  - If ZERO_REG=1, busy[0] is never set.
- o_rbusy[k] = busy[raddr_k], combinational.
  - If BYPASS=1 and a write to raddr_k occurs this cycle, o_rbusy[k]=0.

## Timing
- Read latency: 0 cycles. Data and busy status are combinational from the address, stored state and (when BYPASS=1) current write inputs.
- Write latency: 1 cycle. Without bypass, data is visible on reads the cycle after the edge.
- Clear duration: exactly RF_WORDS rising edges after rst_n deasserts; o_ready rises after the RF_WORDS-th edge. Default: 32 cycles.
- Reset mid-RUN or mid-CLEAR:
  - Immediate return to CLEAR with counter=0, busy cleared, o_ready=0.
  - The full clear restarts after rst_n deasserts.
- No throughput limit: all write ports and i_set_busy can be active every cycle in RUN.

## Test plan
- Reset, then release rst_n: o_ready=0 for 32 edges and 1 after the 32nd; then reading all addresses 0..31 returns 0x00000000.
- In RUN, write port0 addr 5 = 0xDEADBEEF:
  - BYPASS=1: raddr0=5 reads 0xDEADBEEF in the same cycle.
  - BYPASS=0: raddr0=5 reads old 0 in the same cycle and 0xDEADBEEF the next cycle.
- NWRITE=2, both ports write addr 7 (port0 0x11111111, port1 0x22222222): rf[7]=0x22222222, and the bypassed read returns 0x22222222.
- ZERO_REG=1, write addr 0 = 0xFFFFFFFF with i_set_busy on addr 0: raddr=0 reads 0 and o_rbusy=0 on every following cycle.
- Scoreboard:
  - set_busy addr 9: o_rbusy=1 next cycle.
  - Write addr 9 = 0xA5A5A5A5: o_rbusy=0 during the write cycle (BYPASS=1) and stays 0 after.
  - Simultaneous set_busy and write on addr 9: busy=1 after the edge.
- Write addr 3 = 0x12345678 in RUN, then pulse rst_n low for 1 cycle: o_ready=0 and busy=0 immediately; after 32 edges, o_ready=1 and addr 3 reads 0.
